// File: rtl/bmul_seq.sv
// Sequencer that streams signed operand pairs through the fixed-cycle Booth multiplier (bmul).
// Optional zero-operand bypass: define BMUL_SEQ_ZERO_SKIP_EN.
module bmul_seq #(
  parameter int unsigned N       = 4,
  parameter int unsigned RUN_CYC = N + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_mu,
  input  logic [N-1:0]   in_mr,
  output logic           mul_rst,
  output logic           mul_ctrl,
  output logic [N-1:0]   mul_mu,
  output logic [N-1:0]   mul_mr,
  input  logic [2*N-1:0] mul_o,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic           busy
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = (RUN_CYC > 1) ? $clog2(RUN_CYC) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_CAPT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  mu_q, mu_d, mr_q, mr_d;
  logic [PW-1:0] out_p_q, out_p_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          mul_rst_q, mul_rst_d;
  logic          mul_ctrl_q, mul_ctrl_d;
  logic          busy_q, busy_d;
  logic          in_xfer_c, skip_c;

  assign in_xfer_c = in_valid && in_ready_q;

`ifdef BMUL_SEQ_ZERO_SKIP_EN
  assign skip_c = (in_mu == '0) || (in_mr == '0);
`else
  assign skip_c = 1'b0;
`endif

  // Next-state and pin decode; pin values follow the state being entered so they are registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mu_d        = mu_q;
    mr_d        = mr_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_xfer_c) begin
          if (skip_c) begin
            out_p_d     = '0;
            out_valid_d = 1'b1;
          end else begin
            mu_d    = in_mu;
            mr_d    = in_mr;
            state_d = S_CLR;
          end
        end
      end
      S_CLR:  state_d = S_LOAD;
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == CW'(RUN_CYC - 1)) state_d = S_CAPT;
        else                           cnt_d   = cnt_q + CW'(1);
      end
      S_CAPT: begin
        out_p_d     = mul_o;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE) && !out_valid_d;
    mul_rst_d  = (state_d != S_CLR);
    mul_ctrl_d = (state_d == S_RUN);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mu_q        <= '0;
      mr_q        <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      mul_rst_q   <= 1'b0;
      mul_ctrl_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mu_q        <= mu_d;
      mr_q        <= mr_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      mul_rst_q   <= mul_rst_d;
      mul_ctrl_q  <= mul_ctrl_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_rst   = mul_rst_q;
  assign mul_ctrl  = mul_ctrl_q;
  assign mul_mu    = mu_q;
  assign mul_mr    = mr_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bmul_seq.sv
// Directed bench for bmul_seq with a behavioural registered multiplier standing in for bmul.
module tb_bmul_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_mu = '0;
  logic [3:0] in_mr = '0;
  logic       mul_rst, mul_ctrl;
  logic [3:0] mul_mu, mul_mr;
  logic [7:0] mul_o = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_p;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bmul_seq #(.N(4), .RUN_CYC(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mu(in_mu), .in_mr(in_mr), .mul_rst(mul_rst), .mul_ctrl(mul_ctrl),
    .mul_mu(mul_mu), .mul_mr(mul_mr), .mul_o(mul_o), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .busy(busy)
  );

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] sa, sb;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    return 8'(sa * sb);
  endfunction

  // Stand-in for bmul: cleared while rst is low, registers the product while processing.
  always @(posedge clk) begin
    if (!mul_rst)      mul_o <= '0;
    else if (mul_ctrl) mul_o <= ref_mul(mul_mu, mul_mr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] mu;
    logic [3:0] mr;
    logic [7:0] p;
    int         lat;
    int         lo;
    int         hi;
  } vec_t;

  vec_t vecs[7];

  task automatic do_op(input vec_t v);
    int  w, lat, lo, hi;
    bit  held;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_mu    = v.mu;
    in_mr    = v.mr;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; lo = 0; hi = 0; held = 1'b1;
    while (!out_valid && lat < 40) begin
      if (!mul_rst) lo++;
      if (mul_ctrl) hi++;
      if (mul_mu !== v.mu || mul_mr !== v.mr) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("out_p", 32'(out_p), 32'(v.p));
    chk("mul_rst_low_cycles", 32'(lo), 32'(v.lo));
    chk("mul_ctrl_high_cycles", 32'(hi), 32'(v.hi));
    chk("operands_held", 32'(held), 32'd1);
    @(negedge clk);
    chk("out_valid_drained", 32'(out_valid), 32'd0);
    chk("in_ready_after_drain", 32'(in_ready), 32'd1);
  endtask

  logic [3:0] b2b_mu [4];
  logic [3:0] b2b_mr [4];
  logic [7:0] b2b_p  [4];

  initial begin
    int   zlat, zlo, zhi, cyc, k, i, extra;
    logic [7:0] held_p;
    bit   acc;

`ifdef BMUL_SEQ_ZERO_SKIP_EN
    zlat = 0; zlo = 0; zhi = 0;
`else
    zlat = 8; zlo = 1; zhi = 5;
`endif
    vecs[0] = '{4'h3, 4'h2, 8'h06, 8, 1, 5};
    vecs[1] = '{4'hD, 4'h2, 8'hFA, 8, 1, 5};
    vecs[2] = '{4'h8, 4'h8, 8'h40, 8, 1, 5};
    vecs[3] = '{4'h7, 4'h8, 8'hC8, 8, 1, 5};
    vecs[4] = '{4'hF, 4'hF, 8'h01, 8, 1, 5};
    vecs[5] = '{4'h7, 4'h7, 8'h31, 8, 1, 5};
    vecs[6] = '{4'h0, 4'h5, 8'h00, zlat, zlo, zhi};

    b2b_mu = '{4'h5, 4'hA, 4'h9, 4'h1};
    b2b_mr = '{4'h3, 4'h6, 4'hE, 4'hF};
    b2b_p  = '{8'h0F, 8'hDC, 8'h0E, 8'hFF};

    // Power-on reset values
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_rst", 32'(mul_rst), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_mul_rst", 32'(mul_rst), 32'd1);

    for (int j = 0; j < 7; j++) do_op(vecs[j]);

    // Reset asserted in the middle of RUN
    in_valid = 1'b1; in_mu = 4'h6; in_mr = 4'h5;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!mul_ctrl && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_run", 32'(mul_ctrl), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mul_ctrl", 32'(mul_ctrl), 32'd0);
    chk("midrst_mul_rst", 32'(mul_rst), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_mul_mu", 32'(mul_mu), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_release_in_ready", 32'(in_ready), 32'd1);
    extra = 0;
    for (int j = 0; j < 12; j++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    chk("no_partial_product", 32'(extra), 32'd0);

    // Backpressure hold
    out_ready = 1'b0;
    in_valid = 1'b1; in_mu = 4'hD; in_mr = 4'h3;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_out_p", 32'(out_p), 32'h000000F7);
    held_p = out_p;
    extra = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (!out_valid || out_p !== held_p || in_ready) extra++;
    end
    chk("bp_hold_violations", 32'(extra), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_out_valid", 32'(out_valid), 32'd0);
    chk("bp_drain_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream with in_valid held high
    k = 0;
    fork
      begin
        i = 0; cyc = 0;
        while (i < 4 && cyc < 200) begin
          in_mu = b2b_mu[i]; in_mr = b2b_mr[i]; in_valid = 1'b1;
          acc = in_ready;
          @(negedge clk);
          cyc++;
          if (acc) i++;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 300 && k < 4; c++) begin
          @(negedge clk);
          if (out_valid) begin
            chk("b2b_out_p", 32'(out_p), 32'(b2b_p[k]));
            chk("b2b_ref_model", 32'(out_p), 32'(ref_mul(b2b_mu[k], b2b_mr[k])));
            k++;
          end
        end
      end
    join
    chk("b2b_count", 32'(k), 32'd4);
    extra = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("b2b_no_duplicates", 32'(extra), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
